// File: rtl/grid_writer.sv
// Playfield writer: locks landed pieces, clears full rows, and
// publishes a composited back buffer while idle.
module grid_writer (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         lock_valid,
   output logic         lock_ready,
   input  logic [31:0]  cell_xy,
   input  logic [143:0] piece_mask,
   input  logic         draw_finish,
   output logic [143:0] data_swap,
   output logic [2:0]   rows_cleared,
   output logic         clear_done,
   output logic         collision,
   output logic         busy
);

   typedef enum logic [2:0] {
      IDLE,
      LOCK,
      SCAN,
      SHIFT,
      DONE
   } state_t;

   localparam logic [4:0] LAST_ROW = 5'd17;

   state_t         state;
   logic [143:0]   field;
   logic [4:0]     row_ptr;
   logic [4:0]     scan_row;
   logic [143:0]   lock_next;
   logic           lock_coll;
   logic           row_full;
   logic [4:0]     row_above;

   assign lock_ready = (state == IDLE);
   assign busy       = (state != IDLE);
   assign row_full   = &field[{row_ptr, 3'b000} +: 8];
   assign row_above  = row_ptr - 5'd1;

   // Occupancy is tested against the pre-lock field so duplicates never collide.
   always_comb begin
      lock_next = field;
      lock_coll = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (cell_xy[8*k+3 +: 5] > LAST_ROW) begin
            lock_coll = 1'b1;
         end else begin
            if (field[cell_xy[8*k +: 8]])
               lock_coll = 1'b1;
            lock_next[cell_xy[8*k +: 8]] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         field        <= '0;
         data_swap    <= '0;
         rows_cleared <= 3'd0;
         clear_done   <= 1'b0;
         collision    <= 1'b0;
         row_ptr      <= LAST_ROW;
         scan_row     <= 5'd0;
      end else begin
         clear_done <= 1'b0;
         if (state == IDLE && !draw_finish)
            data_swap <= field | piece_mask;
         unique case (state)
            IDLE: begin
               if (lock_valid) begin
                  rows_cleared <= 3'd0;
                  state        <= LOCK;
               end
            end
            LOCK: begin
               field   <= lock_next;
               row_ptr <= LAST_ROW;
               state   <= SCAN;
               if (lock_coll)
                  collision <= 1'b1;
            end
            SCAN: begin
               if (row_full) begin
                  scan_row <= row_ptr;
                  if (rows_cleared != 3'd4)
                     rows_cleared <= rows_cleared + 3'd1;
                  state <= SHIFT;
               end else if (row_ptr == 5'd0) begin
                  state <= DONE;
               end else begin
                  row_ptr <= row_above;
               end
            end
            SHIFT: begin
               if (row_ptr == 5'd0) begin
                  field[7:0] <= 8'h00;
                  row_ptr    <= scan_row;
                  state      <= SCAN;
               end else begin
                  field[{row_ptr, 3'b000} +: 8] <=
                     field[{row_above, 3'b000} +: 8];
                  row_ptr <= row_above;
               end
            end
            DONE: begin
               clear_done <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_grid_writer.sv
// Self-checking bench for grid_writer: directed table, corner
// sequences and randomized locks against a row-array model.
module tb_grid_writer;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         lock_valid;
   logic         lock_ready;
   logic [31:0]  cell_xy;
   logic [143:0] piece_mask;
   logic         draw_finish;
   logic [143:0] data_swap;
   logic [2:0]   rows_cleared;
   logic         clear_done;
   logic         collision;
   logic         busy;

   always #5 clk = ~clk;

   grid_writer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .lock_valid   (lock_valid),
      .lock_ready   (lock_ready),
      .cell_xy      (cell_xy),
      .piece_mask   (piece_mask),
      .draw_finish  (draw_finish),
      .data_swap    (data_swap),
      .rows_cleared (rows_cleared),
      .clear_done   (clear_done),
      .collision    (collision),
      .busy         (busy)
   );

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0] mrow [18];
   bit         mcoll;

   typedef struct {
      logic [31:0] cells;
      int          exp_rc;
      bit          exp_coll;
      int          exp_lat;
      logic [7:0]  exp_row17;
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string name, input logic [143:0] act,
                      input logic [143:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] cxy(input int x, input int y);
      return 8'(y * 8 + x);
   endfunction

   function automatic logic [31:0] cells4(input int x0, input int y0,
                                          input int x1, input int y1,
                                          input int x2, input int y2,
                                          input int x3, input int y3);
      return {cxy(x3, y3), cxy(x2, y2), cxy(x1, y1), cxy(x0, y0)};
   endfunction

   function automatic logic [143:0] mfield();
      logic [143:0] f;
      f = '0;
      for (int y = 0; y < 18; y++)
         f[8*y +: 8] = mrow[y];
      return f;
   endfunction

   task automatic model_reset();
      for (int y = 0; y < 18; y++)
         mrow[y] = 8'h00;
      mcoll = 1'b0;
   endtask

   // Cells land, then full rows collapse from the bottom up; each
   // collapse of row r costs a re-scan plus r+1 shift cycles.
   task automatic model_lock(input logic [31:0] cells, output int rc,
                             output int lat);
      logic [7:0] orig [18];
      int r;
      orig = mrow;
      for (int k = 0; k < 4; k++) begin
         int x, y;
         y = int'(cells[8*k+3 +: 5]);
         x = int'(cells[8*k +: 3]);
         if (y > 17) begin
            mcoll = 1'b1;
         end else begin
            if (orig[y][x]) mcoll = 1'b1;
            mrow[y][x] = 1'b1;
         end
      end
      rc  = 0;
      lat = 20;
      r   = 17;
      while (1) begin
         if (mrow[r] == 8'hFF) begin
            rc  = (rc < 4) ? rc + 1 : 4;
            lat = lat + r + 2;
            for (int i = r; i > 0; i--)
               mrow[i] = mrow[i-1];
            mrow[0] = 8'h00;
         end else if (r == 0) begin
            break;
         end else begin
            r--;
         end
      end
   endtask

   task automatic do_lock(input logic [31:0] cells, input logic df,
                          output int lat);
      @(negedge clk);
      chk("ready_before_lock", 144'(lock_ready), 144'(1));
      lock_valid  = 1'b1;
      cell_xy     = cells;
      draw_finish = df;
      @(posedge clk);
      #1;
      lock_valid = 1'b0;
      chk("busy_after_accept", 144'(busy), 144'(1));
      chk("ready_low_busy", 144'(lock_ready), 144'(0));
      lat = 0;
      while (!clear_done && lat < 300) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("clear_done_seen", 144'(clear_done), 144'(1));
      @(posedge clk);
      #1;
      chk("clear_done_pulse", 144'(clear_done), 144'(0));
   endtask

   initial begin
      int lat, rc, mlat;
      logic [143:0] held;

      tbl[0] = '{cells4(0,17, 1,17, 2,17, 3,17), 0, 1'b0, 20, 8'h0F};
      tbl[1] = '{cells4(4,17, 5,17, 6,17, 6,17), 0, 1'b0, 20, 8'h7F};
      tbl[2] = '{cells4(0,16, 1,16, 2,16, 3,16), 0, 1'b0, 20, 8'h7F};
      tbl[3] = '{cells4(4,16, 5,16, 6,16, 4,16), 0, 1'b0, 20, 8'h7F};
      tbl[4] = '{cells4(7,16, 7,17, 6,15, 7,15), 2, 1'b0, 58, 8'hC0};
      tbl[5] = '{cells4(0,20, 0,0, 1,0, 2,0),    0, 1'b1, 20, 8'hC0};
      tbl[6] = '{cells4(0,0, 3,3, 4,4, 5,5),     0, 1'b1, 20, 8'hC0};

      rst_n       = 1'b0;
      lock_valid  = 1'b0;
      cell_xy     = '0;
      piece_mask  = 144'h8;
      draw_finish = 1'b0;
      model_reset();

      repeat (2) @(posedge clk);
      #1;
      chk("rst_data_swap", data_swap, '0);
      chk("rst_lock_ready", 144'(lock_ready), 144'(1));
      chk("rst_busy", 144'(busy), 144'(0));
      chk("rst_rows_cleared", 144'(rows_cleared), 144'(0));
      chk("rst_clear_done", 144'(clear_done), 144'(0));
      chk("rst_collision", 144'(collision), 144'(0));

      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("mask_bit3_after_release", 144'(data_swap[3]), 144'(1));
      @(negedge clk);
      piece_mask = '0;

      for (int i = 0; i < 7; i++) begin
         model_lock(tbl[i].cells, rc, mlat);
         do_lock(tbl[i].cells, 1'b0, lat);
         chk($sformatf("tbl%0d_latency", i), 144'(lat), 144'(tbl[i].exp_lat));
         chk($sformatf("tbl%0d_model_lat", i), 144'(lat), 144'(mlat));
         chk($sformatf("tbl%0d_rows_cleared", i), 144'(rows_cleared),
             144'(tbl[i].exp_rc));
         chk($sformatf("tbl%0d_collision", i), 144'(collision),
             144'(tbl[i].exp_coll));
         chk($sformatf("tbl%0d_row17", i), 144'(data_swap[143:136]),
             144'(tbl[i].exp_row17));
         chk($sformatf("tbl%0d_field", i), data_swap, mfield());
      end

      // draw_finish held across a lock and idle cycles freezes the buffer
      held = mfield();
      @(negedge clk);
      piece_mask  = 144'h5A << 40;
      draw_finish = 1'b1;
      model_lock(cells4(1,1, 2,1, 3,1, 4,1), rc, mlat);
      do_lock(cells4(1,1, 2,1, 3,1, 4,1), 1'b1, lat);
      chk("df_latency", 144'(lat), 144'(20));
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("df_hold", data_swap, held);
      end
      @(negedge clk);
      draw_finish = 1'b0;
      @(posedge clk);
      #1;
      chk("df_release", data_swap, mfield() | piece_mask);

      // reset asserted while a row shift is in flight
      @(negedge clk);
      piece_mask = '0;
      model_lock(cells4(0,17, 1,17, 2,17, 3,17), rc, mlat);
      do_lock(cells4(0,17, 1,17, 2,17, 3,17), 1'b0, lat);
      chk("pre_shift_row17", 144'(data_swap[143:136]), 144'(8'hCF));
      @(negedge clk);
      lock_valid = 1'b1;
      cell_xy    = cells4(4,17, 5,17, 4,17, 5,17);
      @(posedge clk);
      #1;
      lock_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("mid_shift_busy", 144'(busy), 144'(1));
      rst_n = 1'b0;
      #1;
      chk("abort_data_swap", data_swap, '0);
      chk("abort_busy", 144'(busy), 144'(0));
      chk("abort_lock_ready", 144'(lock_ready), 144'(1));
      chk("abort_rows_cleared", 144'(rows_cleared), 144'(0));
      chk("abort_collision", 144'(collision), 144'(0));
      chk("abort_clear_done", 144'(clear_done), 144'(0));
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_abort_ready", 144'(lock_ready), 144'(1));
      chk("post_abort_field", data_swap, '0);

      for (int n = 0; n < 40; n++) begin
         logic [31:0] cells;
         for (int k = 0; k < 4; k++) begin
            int x, y;
            x = $urandom_range(0, 7);
            if ($urandom_range(0, 15) == 0)
               y = $urandom_range(18, 31);
            else
               y = 17 - $urandom_range(0, 3);
            cells[8*k +: 8] = cxy(x, y);
         end
         @(negedge clk);
         piece_mask = {$urandom, $urandom, $urandom, $urandom, $urandom};
         model_lock(cells, rc, mlat);
         do_lock(cells, 1'b0, lat);
         chk($sformatf("rnd%0d_latency", n), 144'(lat), 144'(mlat));
         chk($sformatf("rnd%0d_rows_cleared", n), 144'(rows_cleared),
             144'(rc));
         chk($sformatf("rnd%0d_collision", n), 144'(collision),
             144'(mcoll));
         chk($sformatf("rnd%0d_data_swap", n), data_swap,
             mfield() | piece_mask);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/grid_writer.md
GRID_WRITER -- requirements
Module: grid_writer

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 rst_n  in  1  asynchronous active-low reset; assertion takes effect immediately, release is sampled on clk.
REQ-003 lock_valid  in  1  request to lock a landed piece into the field.
REQ-004 lock_ready  out  1  high exactly when state is IDLE.
REQ-005 cell_xy  in  32  four cells; cell k occupies bits [8k+7:8k] = {y[4:0], x[2:0]}.
REQ-006 piece_mask  in  144  falling-piece overlay, same layout as the field.
REQ-007 draw_finish  in  1  frame-end strobe from the display storage side.
REQ-008 data_swap  out  144  back buffer; bit index = x + 8*y; row y occupies [8y+7:8y]; row 0 is top.
REQ-009 rows_cleared  out  3  rows removed by the last lock, 0..4.
REQ-010 clear_done  out  1  one-cycle pulse when lock processing completes.
REQ-011 collision  out  1  sticky; set when a locked cell was already occupied or has y>17.
REQ-012 busy  out  1  high in every state except IDLE.

Function
REQ-013 Internal 144-bit field holds the locked cells; the falling piece is never stored in it.
REQ-014 States: IDLE, LOCK, SCAN, SHIFT, DONE.
REQ-015 IDLE: lock_valid=1 at a rising edge -> handshake accepted; go to LOCK; rows_cleared <= 0.
REQ-016 LOCK, one cycle:
- For each k with y<=17: set field bit x+8*y.
- Cell with y>17: no write; collision <= 1.
- Cell already set in the field: collision <= 1.
- Duplicate cells in one request: written once, no collision.
- Then row_ptr <= 17; go to SCAN.
REQ-017 SCAN, one row per cycle:
- Row row_ptr all ones -> save row_ptr as scan_row; increment rows_cleared, saturating at 4; go to SHIFT.
- Else if row_ptr==0 -> go to DONE.
- Else row_ptr <= row_ptr-1.
REQ-018 SHIFT, one row per cycle, starting at scan_row and moving up:
- Row r <= row r-1.
- At r==0: row 0 <= 0, row_ptr <= scan_row, go to SCAN, so the shifted-down row is re-checked.
- Clearing row r therefore takes r+1 cycles.
REQ-019 DONE, one cycle: clear_done=1; go to IDLE; rows_cleared holds until the next accepted lock.
REQ-020 Latency, no clears: accept edge -> LOCK -> 18 SCAN cycles -> DONE; clear_done high 20 cycles after the accept edge.
REQ-021 data_swap <= field | piece_mask on every edge where state==IDLE and draw_finish==0; it holds in all other cycles, so partially shifted fields are never exposed.
REQ-022 draw_finish high together with an accepted lock: data_swap holds; the lock is still accepted.
REQ-023 lock_valid while busy is ignored (lock_ready=0); the source holds the request until it is accepted.
REQ-024 collision clears only on reset.

Reset
REQ-025 Reset state:
- field = 0, data_swap = 0, state = IDLE.
- lock_ready = 1, busy = 0.
- rows_cleared = 0, clear_done = 0, collision = 0.
- row_ptr = 17, scan_row = 0.
REQ-026 Reset in any state aborts processing immediately; the partially updated field is discarded (zeroed).

Verification
REQ-027 Reset, piece_mask bit 3 set, draw_finish=0 -> data_swap bit 3 =1 one cycle after reset release.
REQ-028 Lock cells (0,17),(1,17),(2,17),(3,17) into an empty field -> clear_done 20 cycles after accept; rows_cleared=0; data_swap[139:136]=4'hF; collision=0.
REQ-029 Field rows 16 and 17 full except x=7; lock (7,16),(7,17),(6,15),(7,15) ->
- rows_cleared=2.
- Row 17 = 8'hC0 (the former row 15).
- Rows 0..16 = 0.
- clear_done after 1+1+(18+17+18)... scan/shift count per REQ-017/018.
REQ-030 Lock a cell with y=20 -> collision=1 and that cell is not written; second lock at an occupied cell -> collision stays 1.
REQ-031 Hold draw_finish=1 during a lock and while in IDLE -> data_swap unchanged until draw_finish=0 in IDLE.
REQ-032 Assert rst_n=0 during SHIFT -> all outputs at reset values immediately; lock_ready=1 after release.
